seq_nonrestoring_divider: RTL



---
 rtl/seq_nonrestoring_divider_pkg.sv | 16 +
 rtl/seq_nonrestoring_divider_cla_addsub.sv | 66 ++++++
 rtl/seq_nonrestoring_divider.sv | 102 ++++++++++
 3 files changed

// File: rtl/seq_nonrestoring_divider_pkg.sv
// Shared constants for the sequential non-restoring divider: FSM encoding,
// default operand width and the iteration-counter width helper.
package seq_nonrestoring_divider_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_nonrestoring_divider_cla_addsub.sv
// W-bit carry-lookahead adder/subtractor: 4-bit lookahead groups feeding a
// group-level lookahead unit. sub=1 computes a - b; carry-out is not produced.
module cla_addsub #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  // Groups that own some bit of the result; only the lower NG-1 need a
  // group generate/propagate, since nothing consumes the top carry-out.
  localparam int NG = (W - 1) / 4 + 1;

  logic [W-1:0]  bb, p, c;
  logic [W-2:0]  g;
  logic [NG-2:0] gg, gp;
  logic [NG-1:0] gc;

  assign bb  = b ^ {W{sub}};
  assign p   = a ^ bb;
  assign g   = a[W-2:0] & bb[W-2:0];
  assign sum = p ^ c;

  always_comb begin
    logic acc, pr;
    acc = 1'b0;
    pr  = 1'b1;
    gg  = '0;
    gp  = '0;
    gc  = '0;
    c   = '0;
    for (int k = 0; k < NG - 1; k++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int i = 4 * k + 3; i >= 4 * k; i--) begin
        acc = acc | (pr & g[i]);
        pr  = pr & p[i];
      end
      gg[k] = acc;
      gp[k] = pr;
    end
    gc[0] = sub;
    for (int k = 1; k < NG; k++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        acc = acc | (pr & gg[j]);
        pr  = pr & gp[j];
      end
      gc[k] = acc | (pr & sub);
    end
    // In-group carries are flattened from the group carry-in as well.
    for (int i = 0; i < W; i++) begin
      acc = 1'b0;
      pr  = 1'b1;
      for (int j = i - 1; j >= 4 * (i / 4); j--) begin
        acc = acc | (pr & g[j]);
        pr  = pr & p[j];
      end
      c[i] = acc | (pr & gc[i / 4]);
    end
  end

endmodule

// File: rtl/seq_nonrestoring_divider.sv
// Sequential unsigned non-restoring divider, one quotient bit per cycle.
// Optional macro DIV_ZERO_DETECT_EN: short-circuits a zero divisor and flags div_err.
module seq_nonrestoring_divider
  import seq_nonrestoring_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_err
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q, m;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   a_sh, as_a, as_sum;
  logic             as_sub;
  logic             zero_div;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_div = (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  assign a_sh = {a[WIDTH-1:0], q[WIDTH-1]};

  // RUN subtracts when the old partial remainder is non-negative; FIX only
  // ever adds the divisor back.
  always_comb begin
    as_a   = a_sh;
    as_sub = ~a[WIDTH];
    if (state == FIX) begin
      as_a   = a;
      as_sub = 1'b0;
    end
  end

  cla_addsub #(.W(WIDTH + 1)) u_addsub (
    .a   (as_a),
    .b   ({1'b0, m}),
    .sub (as_sub),
    .sum (as_sum)
  );

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a         <= '0;
      q         <= '0;
      m         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a       <= '0;
          q       <= dividend;
          m       <= divisor;
          cnt     <= CW'(WIDTH);
          div_err <= zero_div;
          if (zero_div) begin
            quotient  <= '1;
            remainder <= dividend;
            state     <= DONE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          a   <= as_sum;
          q   <= {q[WIDTH-2:0], ~as_sum[WIDTH]};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (a[WIDTH]) a <= as_sum;
          quotient  <= q;
          remainder <= a[WIDTH] ? as_sum[WIDTH-1:0] : a[WIDTH-1:0];
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
